powerup_scheduler: RTL and testbench
====================================

POWERUP_SCHEDULER -- requirements
Module: powerup_scheduler

Interface
REQ-001 SHALL have parameter TICKS_PER_STAGE, default 100000000, clock cycles per duration stage.
REQ-002 SHALL have parameter NUM_STAGES, default 8, stages a held powerup lasts (1..255).
REQ-003 SHALL have parameter COOLDOWN_STAGES, default 4, stages between expiry and respawn (1..255).
REQ-004 SHALL have parameters SPAWN_X, SPAWN_Y, defaults 300, 300, powerup top-left pixel.
REQ-005 SHALL have parameters WIDTH, HEIGHT, defaults 28, 28, sprite box size for players and powerup.
REQ-006 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have ports player0_x, player0_y, player1_x, player1_y  input  32 each  player top-left pixel.
REQ-009 SHALL have ports powerup_x, powerup_y  output  32 each  powerup position; 32'hFFFFFFFF when hidden.
REQ-010 SHALL have ports p0_active, p1_active  output  1 each  player holds the powerup effect.
REQ-011 SHALL have port pickup_pulse  output  1  one-cycle strobe on grant.
REQ-012 SHALL have port stages_left  output  8  remaining HELD stages; 0 outside HELD.
REQ-013 SHALL have port state  output  2  ARMED=0, HELD=1, COOLDOWN=2, SPENT=3.

Function
REQ-014 SHALL run FSM states ARMED, HELD, COOLDOWN, SPENT; all outputs registered.
REQ-015 Player n hit SHALL be: pn_x+WIDTH >= SPAWN_X and pn_x <= SPAWN_X+WIDTH and pn_y+HEIGHT >= SPAWN_Y and pn_y <= SPAWN_Y+HEIGHT; unsigned 32-bit compares, sums computed 33-bit (no wrap).
REQ-016 In ARMED, hit SHALL only be evaluated; powerup_x/y = SPAWN_X/SPAWN_Y.
REQ-017 Single hit in ARMED SHALL, next edge: state=HELD, that player's pn_active=1, pickup_pulse=1 for one cycle, powerup_x/y=all-ones, stages_left=NUM_STAGES.
REQ-018 Simultaneous hits SHALL grant round-robin: priority bit starts at player0 after reset, flips to the other player after each grant (single or tied).
REQ-019 Hits outside ARMED SHALL be ignored; ownership never transfers mid-HELD.
REQ-020 HELD SHALL last exactly NUM_STAGES*TICKS_PER_STAGE cycles: tick counter 0..TICKS_PER_STAGE-1, stages_left decrements on each tick wrap.
REQ-021 On final tick wrap SHALL clear both pn_active, stages_left=0, go to COOLDOWN (or SPENT, see REQ-025) same edge.
REQ-022 COOLDOWN SHALL last exactly COOLDOWN_STAGES*TICKS_PER_STAGE cycles, powerup hidden, then ARMED; a player already overlapping at re-arm is granted one cycle later.
REQ-023 At most one pn_active SHALL be 1 at any time; pickup_pulse never asserts outside the ARMED->HELD transition.

Reset
REQ-024 Reset SHALL, at the next edge and from any state including mid-HELD: state=ARMED, powerup_x/y=SPAWN_X/SPAWN_Y, p0_active=p1_active=0, pickup_pulse=0, stages_left=0, counters=0, priority=player0; reset dominates a same-cycle hit.

Configuration
REQ-025 Macro POWERUP_RESPAWN_EN SHALL control respawn: defined -> expiry goes to COOLDOWN then ARMED (REQ-022); undefined -> expiry goes to SPENT, held forever (powerup hidden, outputs inactive) until reset, COOLDOWN unreachable and its counter logic absent.

Verification (TICKS_PER_STAGE=4, NUM_STAGES=2, COOLDOWN_STAGES=1, SPAWN=(300,300), WIDTH=HEIGHT=28)
REQ-026 p0=(290,310), p1 far -> next edge p0_active=1, pickup_pulse 1 cycle, powerup_x=FFFFFFFF, stages_left 2 then 1 after 4 cycles; p0_active drops after exactly 8 cycles.
REQ-027 Boundary: p0=(272,300) hits (272+28=300); p0=(271,300) never hits; p0=(328,328) hits, (329,300) does not.
REQ-028 Both players at (300,300) after reset -> p0 granted; after COOLDOWN re-arm with both still overlapping -> p1 granted.
REQ-029 POWERUP_RESPAWN_EN defined: after 8-cycle HELD, state=COOLDOWN 4 cycles, then ARMED with powerup_x=300; undefined: state=SPENT, stays hidden 1000 cycles.
REQ-030 Reset asserted at HELD cycle 3 -> next edge state=ARMED, p0_active=0, stages_left=0, powerup_x=300; hit in same cycle as reset produces no grant.

Source files
------------

// File: rtl/powerup_scheduler.sv
// powerup_scheduler
//
// One powerup sits at (SPAWN_X, SPAWN_Y). When a player's sprite box overlaps
// it while ARMED, that player gets the effect for NUM_STAGES stages of
// TICKS_PER_STAGE cycles each. Simultaneous overlaps are resolved round-robin.
// When the effect expires the powerup either respawns after a cooldown or is
// gone for good until reset.
//
// Build option:
//   POWERUP_RESPAWN_EN  defined   -> expiry enters COOLDOWN, then re-arms
//                       undefined -> expiry enters SPENT and stays there;
//                                    the cooldown counter is not built
//
// Ports:
//   clock                   single clock, rising edge
//   reset                   synchronous, active-high
//   player0_x/y, player1_x/y  player sprite top-left pixel
//   powerup_x/y             powerup top-left pixel, all-ones while hidden
//   p0_active, p1_active    player currently holds the effect
//   pickup_pulse            one-cycle strobe on the grant edge
//   stages_left             remaining held stages, 0 outside HELD
//   state                   ARMED=0, HELD=1, COOLDOWN=2, SPENT=3
//
// Handshake: there is none; player positions are sampled every cycle and all
// outputs are registered, so every response appears one edge after the
// inputs that caused it.
module powerup_scheduler #(
    parameter int unsigned TICKS_PER_STAGE = 100000000,
    parameter int unsigned NUM_STAGES      = 8,
    parameter int unsigned COOLDOWN_STAGES = 4,
    parameter int unsigned SPAWN_X         = 300,
    parameter int unsigned SPAWN_Y         = 300,
    parameter int unsigned WIDTH           = 28,
    parameter int unsigned HEIGHT          = 28
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] player0_x,
    input  logic [31:0] player0_y,
    input  logic [31:0] player1_x,
    input  logic [31:0] player1_y,
    output logic [31:0] powerup_x,
    output logic [31:0] powerup_y,
    output logic        p0_active,
    output logic        p1_active,
    output logic        pickup_pulse,
    output logic [7:0]  stages_left,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        HELD     = 2'd1,
        COOLDOWN = 2'd2,
        SPENT    = 2'd3
    } state_t;

    // Overlap bounds are kept 33 bits wide so px + WIDTH cannot wrap.
    localparam logic [32:0] SX_LO     = 33'(SPAWN_X);
    localparam logic [32:0] SX_HI     = 33'(SPAWN_X) + 33'(WIDTH);
    localparam logic [32:0] SY_LO     = 33'(SPAWN_Y);
    localparam logic [32:0] SY_HI     = 33'(SPAWN_Y) + 33'(HEIGHT);
    localparam logic [32:0] W33       = 33'(WIDTH);
    localparam logic [32:0] H33       = 33'(HEIGHT);
    localparam logic [31:0] TICK_LAST = 32'(TICKS_PER_STAGE - 1);
    localparam logic [7:0]  NUM_ST    = 8'(NUM_STAGES);
    localparam logic [31:0] SPAWN_X32 = 32'(SPAWN_X);
    localparam logic [31:0] SPAWN_Y32 = 32'(SPAWN_Y);
    localparam logic [31:0] HIDDEN    = 32'hFFFF_FFFF;

    state_t      st;
    logic [31:0] tick_cnt;
    logic        prio;      // 0: player0 wins a tie, 1: player1 wins a tie
    logic        p0_hit;
    logic        p1_hit;
    logic        grant0;
    logic        grant1;

`ifdef POWERUP_RESPAWN_EN
    localparam logic [7:0] COOL_ST = 8'(COOLDOWN_STAGES);
    logic [7:0] cool_left;
`endif

    function automatic logic box_hit(input logic [31:0] px, input logic [31:0] py);
        logic [32:0] x33;
        logic [32:0] y33;
        x33 = {1'b0, px};
        y33 = {1'b0, py};
        return (x33 + W33 >= SX_LO) && (x33 <= SX_HI) &&
               (y33 + H33 >= SY_LO) && (y33 <= SY_HI);
    endfunction

    assign p0_hit = box_hit(player0_x, player0_y);
    assign p1_hit = box_hit(player1_x, player1_y);
    assign grant0 = p0_hit && (!p1_hit || !prio);
    assign grant1 = p1_hit && (!p0_hit || prio);

    assign state = st;

    always_ff @(posedge clock) begin
        if (reset) begin
            st           <= ARMED;
            tick_cnt     <= '0;
            prio         <= 1'b0;
            powerup_x    <= SPAWN_X32;
            powerup_y    <= SPAWN_Y32;
            p0_active    <= 1'b0;
            p1_active    <= 1'b0;
            pickup_pulse <= 1'b0;
            stages_left  <= '0;
`ifdef POWERUP_RESPAWN_EN
            cool_left    <= '0;
`endif
        end else begin
            pickup_pulse <= 1'b0;
            case (st)
                ARMED: begin
                    if (grant0 || grant1) begin
                        st           <= HELD;
                        p0_active    <= grant0;
                        p1_active    <= grant1;
                        pickup_pulse <= 1'b1;
                        powerup_x    <= HIDDEN;
                        powerup_y    <= HIDDEN;
                        stages_left  <= NUM_ST;
                        tick_cnt     <= '0;
                        // Next tie goes to whoever did not just win.
                        prio         <= grant0;
                    end
                end
                HELD: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (stages_left == 8'd1) begin
                            p0_active   <= 1'b0;
                            p1_active   <= 1'b0;
                            stages_left <= '0;
`ifdef POWERUP_RESPAWN_EN
                            st          <= COOLDOWN;
                            cool_left   <= COOL_ST;
`else
                            st          <= SPENT;
`endif
                        end else begin
                            stages_left <= stages_left - 8'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 32'd1;
                    end
                end
`ifdef POWERUP_RESPAWN_EN
                COOLDOWN: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (cool_left == 8'd1) begin
                            st        <= ARMED;
                            cool_left <= '0;
                            powerup_x <= SPAWN_X32;
                            powerup_y <= SPAWN_Y32;
                        end else begin
                            cool_left <= cool_left - 8'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 32'd1;
                    end
                end
`endif
                default: begin
                    // SPENT: parked with the powerup hidden until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_powerup_scheduler.sv
module tb_powerup_scheduler;

  localparam logic [31:0] FAR    = 32'd1000;
  localparam logic [31:0] HIDDEN = 32'hFFFF_FFFF;

  logic        clock;
  logic        reset;
  logic [31:0] player0_x, player0_y, player1_x, player1_y;
  logic [31:0] powerup_x, powerup_y;
  logic        p0_active, p1_active, pickup_pulse;
  logic [7:0]  stages_left;
  logic [1:0]  state;

  powerup_scheduler #(
    .TICKS_PER_STAGE(4),
    .NUM_STAGES(2),
    .COOLDOWN_STAGES(1),
    .SPAWN_X(300),
    .SPAWN_Y(300),
    .WIDTH(28),
    .HEIGHT(28)
  ) dut (
    .clock(clock),
    .reset(reset),
    .player0_x(player0_x),
    .player0_y(player0_y),
    .player1_x(player1_x),
    .player1_y(player1_y),
    .powerup_x(powerup_x),
    .powerup_y(powerup_y),
    .p0_active(p0_active),
    .p1_active(p1_active),
    .pickup_pulse(pickup_pulse),
    .stages_left(stages_left),
    .state(state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  // expected owner {p1_active, p0_active} for each grant, in order
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_players(input logic [31:0] ax, ay, bx, by);
    player0_x = ax; player0_y = ay; player1_x = bx; player1_y = by;
  endtask

  // one reset edge, released afterwards; state is ARMED when this returns
  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // scoreboard: every pickup strobe pops one expected owner
  always @(negedge clock) begin
    logic [1:0] exp_owner;
    if (mon_en) begin
      checks++;
      if (p0_active && p1_active) begin
        errors++;
        $display("FAIL both_active: p0=%0b p1=%0b required not both at %0t", p0_active, p1_active, $time);
      end
      if (pickup_pulse) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pickup: owner=%0b%0b required no pickup at %0t", p1_active, p0_active, $time);
        end else begin
          exp_owner = exp_q.pop_front();
          if ({p1_active, p0_active} !== exp_owner) begin
            errors++;
            $display("FAIL pickup_owner: got %0b expected %0b at %0t", {p1_active, p0_active}, exp_owner, $time);
          end
        end
      end
    end
  end

  typedef struct {
    logic [31:0] p0x, p0y, p1x, p1y;
    logic [1:0]  grant;   // 0 none, 1 player0, 2 player1
  } vec_t;

  vec_t vec[11];

  initial begin
    vec[0]  = '{32'd290, 32'd310, FAR, FAR, 2'd1};
    vec[1]  = '{32'd272, 32'd300, FAR, FAR, 2'd1};     // 272+28 = 300, touches
    vec[2]  = '{32'd300, 32'd300, 32'd300, 32'd300, 2'd1}; // tie after reset -> p0
    vec[3]  = '{32'd271, 32'd300, FAR, FAR, 2'd0};
    vec[4]  = '{32'd328, 32'd328, FAR, FAR, 2'd1};
    vec[5]  = '{32'd329, 32'd300, FAR, FAR, 2'd0};
    vec[6]  = '{FAR, FAR, 32'd300, 32'd272, 2'd2};
    vec[7]  = '{FAR, FAR, 32'd300, 32'd329, 2'd0};
    vec[8]  = '{FAR, FAR, 32'd300, 32'd271, 2'd0};
    vec[9]  = '{32'hFFFF_FFF0, 32'd300, FAR, FAR, 2'd0}; // no wrap of x+WIDTH
    vec[10] = '{32'd0, 32'd0, 32'd328, 32'd272, 2'd2};

    reset = 1'b1;
    set_players(FAR, FAR, FAR, FAR);
    ticks(2);

    // reset state
    check("rst_state", 32'(state), 32'd0);
    check("rst_powerup_x", powerup_x, 32'd300);
    check("rst_powerup_y", powerup_y, 32'd300);
    check("rst_p0_active", 32'(p0_active), 32'd0);
    check("rst_p1_active", 32'(p1_active), 32'd0);
    check("rst_pickup", 32'(pickup_pulse), 32'd0);
    check("rst_stages", 32'(stages_left), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // table: fresh reset, place players, one edge to evaluate the hit
    for (int i = 0; i < 11; i++) begin
      set_players(vec[i].p0x, vec[i].p0y, vec[i].p1x, vec[i].p1y);
      pulse_reset();
      if (vec[i].grant != 2'd0) exp_q.push_back(vec[i].grant);
      tick();
      check($sformatf("vec%0d_state", i), 32'(state), (vec[i].grant != 2'd0) ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_owner", i), 32'({p1_active, p0_active}), 32'(vec[i].grant));
      check($sformatf("vec%0d_powerup_x", i), powerup_x, (vec[i].grant != 2'd0) ? HIDDEN : 32'd300);
      check($sformatf("vec%0d_stages", i), 32'(stages_left), (vec[i].grant != 2'd0) ? 32'd2 : 32'd0);
      ticks(2);
    end

    // stage timing and expiry
    set_players(32'd290, 32'd310, FAR, FAR);
    pulse_reset();
    exp_q.push_back(2'b01);
    tick();
    check("t_pickup", 32'(pickup_pulse), 32'd1);
    check("t_p0_on", 32'(p0_active), 32'd1);
    check("t_stages2", 32'(stages_left), 32'd2);
    check("t_hidden_y", powerup_y, HIDDEN);
    set_players(FAR, FAR, FAR, FAR);
    tick();
    check("t_pickup_one_cycle", 32'(pickup_pulse), 32'd0);
    ticks(2);
    check("t_stages2_c3", 32'(stages_left), 32'd2);
    tick();
    check("t_stages1_c4", 32'(stages_left), 32'd1);
    ticks(3);
    check("t_p0_still_c7", 32'(p0_active), 32'd1);
    // player walks back over the hidden spot while held: ignored
    set_players(32'd300, 32'd300, 32'd300, 32'd300);
    tick();
    check("t_p0_off_c8", 32'(p0_active), 32'd0);
    check("t_stages0_c8", 32'(stages_left), 32'd0);
    set_players(FAR, FAR, FAR, FAR);
`ifdef POWERUP_RESPAWN_EN
    check("t_cooldown", 32'(state), 32'd2);
    check("t_cool_hidden", powerup_x, HIDDEN);
    ticks(3);
    check("t_cooldown_c11", 32'(state), 32'd2);
    tick();
    check("t_rearmed", 32'(state), 32'd0);
    check("t_rearm_x", powerup_x, 32'd300);
`else
    check("t_spent", 32'(state), 32'd3);
    set_players(32'd300, 32'd300, FAR, FAR);
    ticks(1000);
    check("t_spent_1000", 32'(state), 32'd3);
    check("t_spent_hidden_x", powerup_x, HIDDEN);
    check("t_spent_hidden_y", powerup_y, HIDDEN);
    check("t_spent_p0", 32'(p0_active), 32'd0);
`endif

    // tie, then round-robin after re-arm
    set_players(32'd300, 32'd300, 32'd300, 32'd300);
    pulse_reset();
    exp_q.push_back(2'b01);
    tick();
    check("rr_first_p0", 32'({p1_active, p0_active}), 32'd1);
`ifdef POWERUP_RESPAWN_EN
    exp_q.push_back(2'b10);
    ticks(12);
    check("rr_rearmed", 32'(state), 32'd0);
    tick();
    check("rr_second_p1", 32'({p1_active, p0_active}), 32'd2);
    check("rr_second_pulse", 32'(pickup_pulse), 32'd1);
`else
    ticks(12);
    check("rr_spent", 32'(state), 32'd3);
    check("rr_spent_owner", 32'({p1_active, p0_active}), 32'd0);
`endif

    // reset in the middle of HELD, with the hit still present
    set_players(32'd290, 32'd310, FAR, FAR);
    pulse_reset();
    exp_q.push_back(2'b01);
    tick();
    ticks(2);
    check("mr_held", 32'(state), 32'd1);
    reset = 1'b1;
    tick();
    check("mr_state", 32'(state), 32'd0);
    check("mr_p0", 32'(p0_active), 32'd0);
    check("mr_stages", 32'(stages_left), 32'd0);
    check("mr_powerup_x", powerup_x, 32'd300);
    tick();
    check("mr_no_grant_state", 32'(state), 32'd0);
    check("mr_no_grant_pulse", 32'(pickup_pulse), 32'd0);
    set_players(FAR, FAR, FAR, FAR);
    reset = 1'b0;
    tick();
    check("mr_after_state", 32'(state), 32'd0);
    ticks(2);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // safety net against a stuck run
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, required finish before 1000000");
    $fatal(1, "timeout");
  end

endmodule
